// File: rtl/tug_press_arbiter.sv
// tug_press_arbiter: arbitration and playfield controller for the two-player
// tug-of-war game.
//
// Ports:
//   Clock        system clock, all state updates on posedge
//   Reset        synchronous, active-high reset (returns to IDLE)
//   keyL / keyR  one-cycle press pulses, already synchronized
//   start        begin a game from IDLE or restart one from WIN
//   lights       one-hot playfield light (TRACK_LEN-1 = left edge, 0 = right edge)
//   grantL/R     one-cycle pulse per accepted press
//   winner       00 none, 01 left, 10 right
//   winsL/R      saturating win tallies (0..7), cleared only by Reset
//
// Optional feature macro: TUG_TIE_ROUND_ROBIN_EN
//   Defined:   a tie in PLAY is granted to a toggling priority pointer (L first).
//   Undefined: a tie produces no grant and no movement.

module tug_press_arbiter #(
    parameter int unsigned TRACK_LEN      = 9,
    parameter int unsigned LOCKOUT_CYCLES = 4
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 keyL,
    input  logic                 keyR,
    input  logic                 start,
    output logic [TRACK_LEN-1:0] lights,
    output logic                 grantL,
    output logic                 grantR,
    output logic [1:0]           winner,
    output logic [2:0]           winsL,
    output logic [2:0]           winsR
);

    localparam int unsigned CENTER = (TRACK_LEN - 1) / 2;
    localparam int unsigned LOCK_W = (LOCKOUT_CYCLES == 0) ? 1 : $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [LOCK_W-1:0]    LOCK_LOAD     = LOCK_W'(LOCKOUT_CYCLES);
    localparam logic [TRACK_LEN-1:0] LIGHTS_CENTER = TRACK_LEN'(1) << CENTER;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_WIN  = 2'd2;

    logic [1:0]           state_q,   state_d;
    logic [TRACK_LEN-1:0] lights_q,  lights_d;
    logic                 grant_l_q, grant_l_d;
    logic                 grant_r_q, grant_r_d;
    logic [1:0]           winner_q,  winner_d;
    logic [2:0]           wins_l_q,  wins_l_d;
    logic [2:0]           wins_r_q,  wins_r_d;
    logic [LOCK_W-1:0]    lock_l_q,  lock_l_d;
    logic [LOCK_W-1:0]    lock_r_q,  lock_r_d;
`ifdef TUG_TIE_ROUND_ROBIN_EN
    logic                 prio_q,    prio_d;    // 0 = left wins next tie
`endif

    logic elig_l, elig_r;
    logic take_l, take_r;

    // Next-state, arbitration, movement and tally logic
    always_comb begin
        state_d   = state_q;
        lights_d  = lights_q;
        grant_l_d = 1'b0;
        grant_r_d = 1'b0;
        winner_d  = winner_q;
        wins_l_d  = wins_l_q;
        wins_r_d  = wins_r_q;
        lock_l_d  = lock_l_q;
        lock_r_d  = lock_r_q;
`ifdef TUG_TIE_ROUND_ROBIN_EN
        prio_d    = prio_q;
`endif
        take_l    = 1'b0;
        take_r    = 1'b0;

        elig_l = keyL && (lock_l_q == '0);
        elig_r = keyR && (lock_r_q == '0);

        // Lockout counters free-run down to zero; a grant below reloads them
        if (lock_l_q != '0) lock_l_d = lock_l_q - LOCK_W'(1);
        if (lock_r_q != '0) lock_r_d = lock_r_q - LOCK_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_PLAY;
            end

            ST_PLAY: begin
                if (elig_l && !elig_r)
                    take_l = 1'b1;
                else if (elig_r && !elig_l)
                    take_r = 1'b1;
`ifdef TUG_TIE_ROUND_ROBIN_EN
                else if (elig_l && elig_r) begin
                    take_l = ~prio_q;
                    take_r = prio_q;
                    prio_d = ~prio_q;
                end
`endif

                if (take_l) begin
                    grant_l_d = 1'b1;
                    lock_l_d  = LOCK_LOAD;
                    // A press at the left edge wins instead of shifting
                    if (lights_q[TRACK_LEN-1]) begin
                        winner_d = 2'b01;
                        if (wins_l_q != 3'd7) wins_l_d = wins_l_q + 3'd1;
                        state_d  = ST_WIN;
                    end else begin
                        lights_d = lights_q << 1;
                    end
                end

                if (take_r) begin
                    grant_r_d = 1'b1;
                    lock_r_d  = LOCK_LOAD;
                    if (lights_q[0]) begin
                        winner_d = 2'b10;
                        if (wins_r_q != 3'd7) wins_r_d = wins_r_q + 3'd1;
                        state_d  = ST_WIN;
                    end else begin
                        lights_d = lights_q >> 1;
                    end
                end
            end

            ST_WIN: begin
                if (start) begin
                    state_d  = ST_PLAY;
                    lights_d = LIGHTS_CENTER;
                    winner_d = 2'b00;
                    lock_l_d = '0;
                    lock_r_d = '0;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            lights_q  <= LIGHTS_CENTER;
            grant_l_q <= 1'b0;
            grant_r_q <= 1'b0;
            winner_q  <= 2'b00;
            wins_l_q  <= 3'd0;
            wins_r_q  <= 3'd0;
            lock_l_q  <= '0;
            lock_r_q  <= '0;
`ifdef TUG_TIE_ROUND_ROBIN_EN
            prio_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            lights_q  <= lights_d;
            grant_l_q <= grant_l_d;
            grant_r_q <= grant_r_d;
            winner_q  <= winner_d;
            wins_l_q  <= wins_l_d;
            wins_r_q  <= wins_r_d;
            lock_l_q  <= lock_l_d;
            lock_r_q  <= lock_r_d;
`ifdef TUG_TIE_ROUND_ROBIN_EN
            prio_q    <= prio_d;
`endif
        end
    end

    assign lights = lights_q;
    assign grantL = grant_l_q;
    assign grantR = grant_r_q;
    assign winner = winner_q;
    assign winsL  = wins_l_q;
    assign winsR  = wins_r_q;

endmodule

// File: tb/tb_tug_press_arbiter.sv
// tb_tug_press_arbiter: self-checking bench for tug_press_arbiter.
// Reference model keeps the light as an integer position and lockout as
// "cycle of last grant", compared after every clock edge.

module tb_tug_press_arbiter;

    localparam int unsigned N    = 9;
    localparam int unsigned LOCK = 4;
    localparam int          C    = (N - 1) / 2;

    localparam int M_IDLE = 0;
    localparam int M_PLAY = 1;
    localparam int M_WIN  = 2;

    logic         Clock;
    logic         Reset;
    logic         keyL, keyR, start;
    logic [N-1:0] lights;
    logic         grantL, grantR;
    logic [1:0]   winner;
    logic [2:0]   winsL, winsR;

    tug_press_arbiter #(.TRACK_LEN(N), .LOCKOUT_CYCLES(LOCK)) dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .keyL   (keyL),
        .keyR   (keyR),
        .start  (start),
        .lights (lights),
        .grantL (grantL),
        .grantR (grantR),
        .winner (winner),
        .winsL  (winsL),
        .winsR  (winsR)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    int tests = 0;
    int fails = 0;

    // Reference model state
    int m_state = M_IDLE;
    int m_pos   = C;
    int m_last_l = -1000;
    int m_last_r = -1000;
    int m_gl = 0, m_gr = 0;
    int m_winner = 0;
    int m_wins_l = 0, m_wins_r = 0;
    int m_prio = 0;
    int cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic kl, input logic kr, input logic st, input logic rst);
        int el, er;
        cyc++;
        m_gl = 0;
        m_gr = 0;
        if (rst) begin
            m_state = M_IDLE; m_pos = C; m_winner = 0;
            m_wins_l = 0; m_wins_r = 0; m_prio = 0;
            m_last_l = -1000; m_last_r = -1000;
        end else if (m_state == M_IDLE) begin
            if (st) m_state = M_PLAY;
        end else if (m_state == M_WIN) begin
            if (st) begin
                m_state = M_PLAY; m_pos = C; m_winner = 0;
                m_last_l = -1000; m_last_r = -1000;
            end
        end else begin
            el = (kl && (cyc - m_last_l > int'(LOCK))) ? 1 : 0;
            er = (kr && (cyc - m_last_r > int'(LOCK))) ? 1 : 0;
            if (el && !er) m_gl = 1;
            else if (er && !el) m_gr = 1;
`ifdef TUG_TIE_ROUND_ROBIN_EN
            else if (el && er) begin
                if (m_prio == 0) m_gl = 1; else m_gr = 1;
                m_prio = 1 - m_prio;
            end
`endif
            if (m_gl) begin
                m_last_l = cyc;
                if (m_pos == int'(N) - 1) begin
                    m_winner = 1; m_state = M_WIN;
                    if (m_wins_l < 7) m_wins_l++;
                end else m_pos++;
            end
            if (m_gr) begin
                m_last_r = cyc;
                if (m_pos == 0) begin
                    m_winner = 2; m_state = M_WIN;
                    if (m_wins_r < 7) m_wins_r++;
                end else m_pos--;
            end
        end
    endtask

    // One clock: drive inputs, advance model, sample #1 after the edge
    task automatic step(input logic kl, input logic kr, input logic st, input logic rst);
        logic [N-1:0] exp_lights;
        keyL = kl; keyR = kr; start = st; Reset = rst;
        model(kl, kr, st, rst);
        @(posedge Clock);
        #1;
        exp_lights = N'(1) << m_pos;
        chk("lights", 32'(lights), 32'(exp_lights));
        chk("grantL", 32'(grantL), 32'(m_gl));
        chk("grantR", 32'(grantR), 32'(m_gr));
        chk("winner", 32'(winner), 32'(m_winner));
        chk("winsL",  32'(winsL),  32'(m_wins_l));
        chk("winsR",  32'(winsR),  32'(m_wins_r));
        keyL = 1'b0; keyR = 1'b0; start = 1'b0; Reset = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Press then wait out the lockout so the next press is eligible
    task automatic spaced(input logic kl, input logic kr);
        step(kl, kr, 1'b0, 1'b0);
        idle(int'(LOCK));
    endtask

    initial begin
        keyL = 1'b0; keyR = 1'b0; start = 1'b0; Reset = 1'b1;

        // Reset state and first grant
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("reset_lights", 32'(lights), 32'(9'b000010000));
        step(1'b1, 1'b0, 1'b0, 1'b0);          // IDLE ignores keys
        step(1'b0, 1'b0, 1'b1, 1'b0);          // start
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("first_grant_lights", 32'(lights), 32'(9'b000100000));
        chk("first_grant_pulse", 32'(grantL), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("grant_one_cycle", 32'(grantL), 32'd0);

        // Mashing: six consecutive presses right after a grant
        idle(int'(LOCK));
        step(1'b1, 1'b0, 1'b0, 1'b0);          // grant -> index 6
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("mash_lights", 32'(lights), 32'(9'b010000000));

        // Tie from center
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        idle(int'(LOCK));
        step(1'b1, 1'b1, 1'b0, 1'b0);

        // Right player wins with spaced presses, then restart
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) spaced(1'b0, 1'b1);
        chk("r_win_winner", 32'(winner), 32'd2);
        chk("r_win_tally", 32'(winsR), 32'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("restart_lights", 32'(lights), 32'(9'b000010000));
        chk("restart_winsR", 32'(winsR), 32'd1);

        // Eight left wins: tally saturates at 7
        for (int w = 0; w < 8; w++) begin
            for (int p = 0; p < 5; p++) spaced(1'b1, 1'b0);
            step(1'b0, 1'b0, 1'b1, 1'b0);
        end
        chk("winsL_sat", 32'(winsL), 32'd7);

        // Reset mid-game at index 7, keys ignored until start
        for (int p = 0; p < 3; p++) spaced(1'b1, 1'b0);
        chk("pre_reset_lights", 32'(lights), 32'(9'b010000000));
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("mid_reset_winsL", 32'(winsL), 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);

        // Randomized play against the model
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 299) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tug_press_arbiter.md
Name: tug_press_arbiter

Overview:
- Arbitration and playfield controller for the two-player tug-of-war game.
- Consumes the single-cycle press pulses produced by the per-player key-press (release-edge) detectors.
- Decides each cycle which press, if any, is granted, and applies per-player lockout against key mashing.
- Moves the one-hot playfield light, detects a win and keeps saturating win tallies for the HEX display logic.

Parameters:
- TRACK_LEN, 9: number of playfield lights. Must be odd and >= 3. Center index C = (TRACK_LEN-1)/2. Index TRACK_LEN-1 is the left edge; index 0 is the right edge.
- LOCKOUT_CYCLES, 4: cycles after a grant during which the same player's presses are ignored. A value of 0 disables lockout.

Ports:
- Clock  input  1  system clock; all state updates on posedge.
- Reset  input  1  synchronous, active-high reset.
- keyL  input  1  left-player press pulse, one cycle wide, already synchronized.
- keyR  input  1  right-player press pulse, one cycle wide, already synchronized.
- start  input  1  pulse: begin a game from IDLE, or restart a game from WIN.
- lights  output  TRACK_LEN  one-hot playfield light, registered.
- grantL  output  1  one-cycle pulse: left press accepted, registered.
- grantR  output  1  one-cycle pulse: right press accepted, registered.
- winner  output  2  00 none, 01 left, 10 right; 11 never driven.
- winsL  output  3  left win tally, saturates at 7.
- winsR  output  3  right win tally, saturates at 7.
- Clock Clock, reset Reset: synchronous, active-high.

Behaviour:
- Reset has priority over all inputs and returns the block to IDLE, including mid-game. Reset values:
  - lights = one-hot at C
  - grantL = grantR = 0
  - winner = 00
  - winsL = winsR = 0
  - both lockout counters = 0
- FSM states: IDLE, PLAY, WIN.
  - IDLE: key inputs ignored; start -> PLAY.
  - PLAY: start ignored; win condition -> WIN.
  - WIN: keys ignored; start -> PLAY with lights recentered to C, winner cleared to 00, lockout counters cleared.
- Eligibility in PLAY: player X is eligible iff keyX=1 and lockX=0 at the sampling edge.
- Arbitration (PLAY only):
  - Only L eligible -> grant L.
  - Only R eligible -> grant R.
  - Both eligible -> tie: no grant, no movement (default build).
  - One pressed but locked, the other eligible -> the eligible player is granted.
- Latency: a press sampled at edge k produces grant, lights update and winner update all visible after edge k.
  - grantX is high for exactly one cycle per accepted press.
- Movement: grant L shifts lights one position toward index TRACK_LEN-1; grant R shifts it one position toward index 0.
- Win rules:
  - Grant L while lights is already at index TRACK_LEN-1 -> no shift, winner = 01, winsL += 1 (saturating), enter WIN.
  - Grant R while lights is at index 0 -> no shift, winner = 10, winsR += 1 (saturating), enter WIN.
  - grantX still pulses on the winning press.
- Lockout:
  - On grant to X, lockX loads LOCKOUT_CYCLES.
  - lockX decrements by 1 each cycle while nonzero; it never underflows.
  - Counter width is $clog2(LOCKOUT_CYCLES+1), with a minimum of 1.
  - Result: X's presses at edges k+1 .. k+LOCKOUT_CYCLES are ignored; the press at edge k+LOCKOUT_CYCLES+1 is accepted.
  - The opponent is never affected by X's lockout.
- Tallies: winsL and winsR hold at 7 on a further win and are cleared only by Reset, never by start.
- lights is exactly one-hot in every cycle.

Optional Feature:
- Macro: TUG_TIE_ROUND_ROBIN_EN.
- Defined:
  - A tie in PLAY grants the player indicated by a 1-bit priority pointer, which is then toggled.
  - The pointer is L after Reset and changes only on ties.
  - The granted player is locked out normally; the loser's press is dropped.
- Undefined: a tie produces no grant and no movement, and no pointer register exists.

Test Plan (TRACK_LEN=9, LOCKOUT_CYCLES=4):
- Reset, then start, then a keyL pulse -> after the next edge grantL=1 for 1 cycle and lights=9'b000100000 (index 5). winner stays 00.
- keyL pulses on 6 consecutive edges after a grant -> edges 1-4 ignored (lights unchanged, grantL=0); edge 5 accepted (lights at index 6); edge 6 ignored.
- keyL and keyR eligible on the same edge, default build -> no grant, lights stay at index 4. With TUG_TIE_ROUND_ROBIN_EN: the first tie grants L (index 5) and the second tie, once both lockouts are clear, grants R (index 4).
- Drive keyR with spaced pulses 5 times from C -> lights reaches index 0 after 4 grants. The 5th grant gives winner=10 and winsR=1; further keyL/keyR are ignored; start -> lights at index 4, winner=00, winsR still 1.
- Win 8 times as left -> winsL saturates at 7. Assert Reset mid-PLAY with lights at index 7 -> next cycle IDLE, lights at index 4, all outputs at reset values, keys ignored until start.
